data_memory_pipe: RTL and testbench



---
 rtl/dmem_pkg.sv | 25 ++
 rtl/data_memory_bank.sv | 30 +++
 rtl/data_memory_pipe.sv | 134 +++++++++++++
 tb/tb_data_memory_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
package dmem_pkg;

    // Controller state: zero-clear sweep after reset, then serving requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dmem_state_e;

    // Number of bytes in one word.
    function automatic int dmem_word_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // Byte-offset width inside a word: log2(DATA_WIDTH/8).
    function automatic int dmem_off(input int data_width);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == (data_width / 8)) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_bank.sv
// Word storage with one byte-enable write port and one synchronous,
// read-first read port sharing a single address.
module data_memory_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [DEPTH_LOG2-1:0]   i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Read returns the word as it was before this edge's write; output holds when not reading.
    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_addr];
        if (i_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/data_memory_pipe.sv
// MEM-stage data memory: valid/ready requests, byte-enable writes,
// 1-cycle registered reads, misalignment flagging and a zero-clear
// sweep after reset. Optional macro DMEM_FORWARD_EN selects write-first
// data for a same-cycle read+write (default: read-first / old word).
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic                    MemWrite,
    input  logic                    MemRead,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic                    MisalignErr
);
    localparam int OFF        = dmem_off(DATA_WIDTH);
    localparam int WORD_BYTES = dmem_word_bytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ONE_A << OFF) - ONE_A;
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

    dmem_state_e              r_state;
    logic [DEPTH_LOG2-1:0]    r_ptr;
    logic                     r_zero;
    logic                     w_acc;
    logic                     w_mis;
    logic                     w_clear;
    logic                     w_bank_we;
    logic                     w_bank_re;
    logic [DEPTH_LOG2-1:0]    w_bank_addr;
    logic [WORD_BYTES-1:0]    w_bank_be;
    logic [DATA_WIDTH-1:0]    w_bank_wdata;
    logic [DATA_WIDTH-1:0]    w_bank_rdata;
    logic                     w_addr_unused;

    // Bits above the word index are ignored: addresses wrap modulo DEPTH words.
    assign w_addr_unused = |(Address >> (OFF + DEPTH_LOG2));

    assign w_clear  = (r_state == ST_CLEAR);
    assign ReqReady = (r_state == ST_IDLE);
    assign w_acc    = ReqValid & ReqReady & ~Reset;
    assign w_mis    = |(Address & OFF_MASK);

    // The clear sweep owns the write port; otherwise accepted aligned requests do.
    assign w_bank_we    = w_clear | (w_acc & MemWrite & ~w_mis);
    assign w_bank_re    = w_acc & MemRead & ~w_mis;
    assign w_bank_addr  = w_clear ? r_ptr : Address[OFF +: DEPTH_LOG2];
    assign w_bank_be    = w_clear ? '1 : ByteEn;
    assign w_bank_wdata = w_clear ? '0 : WriteData;

    data_memory_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_bank_we),
        .i_re    (w_bank_re),
        .i_addr  (w_bank_addr),
        .i_be    (w_bank_be),
        .i_wdata (w_bank_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Clear sweep: one word per cycle from 0 to DEPTH-1, then serve requests until the next reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == PTR_LAST) r_state <= ST_IDLE;
        end
    end

    // Response flags; r_zero forces ReadData to 0 after reset and after a misaligned read, held until the next read.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ReadValid   <= 1'b0;
            MisalignErr <= 1'b0;
            r_zero      <= 1'b1;
        end else begin
            ReadValid   <= w_acc & MemRead;
            MisalignErr <= w_acc & w_mis;
            if (w_acc & MemRead) r_zero <= w_mis;
        end
    end

`ifdef DMEM_FORWARD_EN
    logic [WORD_BYTES-1:0] r_fwd_be;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    // Merge of the old word with new bytes, used to present write-first data.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [WORD_BYTES-1:0] be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Capture the write bytes of a combined read+write so they overlay the read-first word.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_fwd_be <= '0;
        end else if (w_acc & MemRead) begin
            r_fwd_be <= MemWrite ? ByteEn : '0;
        end
    end

    // Data only; no reset needed because r_fwd_be gates it.
    always_ff @(posedge clk) begin
        if (w_acc & MemRead) r_fwd_data <= WriteData;
    end

    assign ReadData = r_zero ? '0 : merge_bytes(w_bank_rdata, r_fwd_data, r_fwd_be);
`else
    assign ReadData = r_zero ? '0 : w_bank_rdata;
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench for data_memory_pipe (DATA_WIDTH=32, DEPTH=1024).
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [63:0] Address = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [3:0]  ByteEn = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        MisalignErr;

    int checks = 0;
    int failures = 0;

    // Reference model: word array plus last returned read data.
    logic [31:0] m_mem [1024];
    logic [31:0] m_last;

    always #5 clk = ~clk;

    data_memory_pipe dut (
        .clk         (clk),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .Address     (Address),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .ByteEn      (ByteEn),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .ReadValid   (ReadValid),
        .MisalignErr (MisalignErr)
    );

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        m_last = 32'h0;
    endtask

    // Present one cycle of request inputs, let the edge happen, and report
    // what the model says the outputs must be just after that edge.
    task automatic drive(input logic v, input logic [63:0] a, input logic wr,
                         input logic rd, input logic [3:0] be, input logic [31:0] wd,
                         output logic e_rv, output logic e_mis, output logic [31:0] e_rd);
        logic [31:0] old_w, new_w;
        int idx;
        ReqValid = v; Address = a; MemWrite = wr; MemRead = rd; ByteEn = be; WriteData = wd;
        @(posedge clk);
        #1;
        e_rv = 1'b0; e_mis = 1'b0;
        if (v) begin
            idx = int'((a / 4) % 1024);
            old_w = m_mem[idx];
            new_w = old_w;
            for (int b = 0; b < 4; b++) if (be[b]) new_w[b*8 +: 8] = wd[b*8 +: 8];
            if ((a % 4) != 0) begin
                e_mis = 1'b1;
                if (rd) begin e_rv = 1'b1; m_last = 32'h0; end
            end else begin
                if (rd) begin
                    e_rv = 1'b1;
`ifdef DMEM_FORWARD_EN
                    m_last = wr ? new_w : old_w;
`else
                    m_last = old_w;
`endif
                end
                if (wr) m_mem[idx] = new_w;
            end
        end
        e_rd = m_last;
        ReqValid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ReqReady !== 1'b0 || ReadValid !== 1'b0 || MisalignErr !== 1'b0 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: ReqReady=%b ReadValid=%b MisalignErr=%b ReadData=%h required 0 0 0 00000000",
                     ReqReady, ReadValid, MisalignErr, ReadData);
        end
        Reset = 1'b0;
        model_clear();
        n = 0;
        while (n < 1500) begin
            @(posedge clk); #1; n++;
            if (ReqReady === 1'b1) break;
        end
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL clear_length: ReqReady rose after %0d cycles required 1024", n);
        end
        drive(1, 64'h40, 0, 1, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadValid !== 1'b1 || ReadData !== 32'h0 || MisalignErr !== 1'b0) begin
            failures++;
            $display("FAIL read_after_clear: ReadValid=%b ReadData=%h MisalignErr=%b required 1 00000000 0",
                     ReadValid, ReadData, MisalignErr);
        end
        drive(0, 64'h0, 0, 0, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadValid !== 1'b0) begin
            failures++;
            $display("FAIL readvalid_pulse: ReadValid=%b required 0", ReadValid);
        end
    endtask

    task automatic test_byte_enable();
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        drive(1, 64'h10, 1, 0, 4'b1111, 32'hDEADBEEF, e_rv, e_mis, e_rd);
        drive(1, 64'h10, 1, 0, 4'b0001, 32'h000000AA, e_rv, e_mis, e_rd);
        drive(1, 64'h10, 0, 1, 4'b0000, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadValid !== 1'b1 || ReadData !== 32'hDEADBEAA) begin
            failures++;
            $display("FAIL byte_enable: ReadValid=%b ReadData=%h required 1 deadbeaa", ReadValid, ReadData);
        end
        drive(1, 64'h10, 1, 0, 4'b0000, 32'h12345678, e_rv, e_mis, e_rd);
        drive(1, 64'h10, 0, 1, 4'b0000, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadData !== 32'hDEADBEAA) begin
            failures++;
            $display("FAIL zero_byteen: ReadData=%h required deadbeaa", ReadData);
        end
        drive(0, 64'h0, 0, 0, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadData !== 32'hDEADBEAA) begin
            failures++;
            $display("FAIL readdata_hold: ReadData=%h required deadbeaa", ReadData);
        end
    endtask

    task automatic test_misalign();
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        drive(1, 64'h13, 0, 1, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (MisalignErr !== 1'b1 || ReadValid !== 1'b1 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL misalign_read: MisalignErr=%b ReadValid=%b ReadData=%h required 1 1 00000000",
                     MisalignErr, ReadValid, ReadData);
        end
        drive(1, 64'h13, 1, 0, 4'b1111, 32'hFFFFFFFF, e_rv, e_mis, e_rd);
        checks++;
        if (MisalignErr !== 1'b1 || ReadValid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_write: MisalignErr=%b ReadValid=%b required 1 0", MisalignErr, ReadValid);
        end
        drive(1, 64'h10, 0, 1, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadData !== 32'hDEADBEAA || MisalignErr !== 1'b0) begin
            failures++;
            $display("FAIL misalign_nowrite: ReadData=%h MisalignErr=%b required deadbeaa 0", ReadData, MisalignErr);
        end
    endtask

    task automatic test_read_write_same_cycle();
        logic e_rv, e_mis;
        logic [31:0] e_rd, want;
        drive(1, 64'h0, 1, 0, 4'b1111, 32'h11111111, e_rv, e_mis, e_rd);
        drive(1, 64'h0, 1, 1, 4'b1111, 32'h22222222, e_rv, e_mis, e_rd);
`ifdef DMEM_FORWARD_EN
        want = 32'h22222222;
`else
        want = 32'h11111111;
`endif
        checks++;
        if (ReadValid !== 1'b1 || ReadData !== want) begin
            failures++;
            $display("FAIL same_cycle_rw: ReadValid=%b ReadData=%h required 1 %h", ReadValid, ReadData, want);
        end
        drive(1, 64'h0, 0, 1, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadData !== 32'h22222222) begin
            failures++;
            $display("FAIL write_then_read: ReadData=%h required 22222222", ReadData);
        end
    endtask

    task automatic test_wrap();
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        drive(1, 64'h1000, 1, 0, 4'b1111, 32'h5, e_rv, e_mis, e_rd);
        drive(1, 64'h0, 0, 1, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadValid !== 1'b1 || ReadData !== 32'h5) begin
            failures++;
            $display("FAIL addr_wrap: ReadValid=%b ReadData=%h required 1 00000005", ReadValid, ReadData);
        end
    endtask

    task automatic test_back_to_back();
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        logic [31:0] vals [3];
        vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1; vals[2] = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) drive(1, 64'(i * 4), 1, 0, 4'b1111, vals[i], e_rv, e_mis, e_rd);
        for (int i = 0; i < 3; i++) begin
            ReqValid = 1'b1; Address = 64'(i * 4); MemRead = 1'b1; MemWrite = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ReadValid !== 1'b1 || ReadData !== vals[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: ReadValid=%b ReadData=%h required 1 %h", i, ReadValid, ReadData, vals[i]);
            end
        end
        ReqValid = 1'b0; MemRead = 1'b0;
        m_last = vals[2];
    endtask

    task automatic test_random();
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        logic [63:0] a;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            a = {32'($urandom), 32'($urandom_range(0, 63))};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive(1'($urandom_range(0, 3) != 0), a, 1'($urandom), 1'($urandom),
                  4'($urandom), 32'($urandom), e_rv, e_mis, e_rd);
            checks++;
            if (ReadValid !== e_rv || MisalignErr !== e_mis || ReadData !== e_rd) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: rv=%b mis=%b rd=%h required %b %b %h",
                             i, ReadValid, MisalignErr, ReadData, e_rv, e_mis, e_rd);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic e_rv, e_mis;
        logic [31:0] e_rd;
        // Reset wins over a request presented on the same edge.
        Reset = 1'b1; ReqValid = 1'b1; MemRead = 1'b1; Address = 64'h10;
        @(posedge clk); #1;
        ReqValid = 1'b0; MemRead = 1'b0;
        checks++;
        if (ReadValid !== 1'b0 || ReqReady !== 1'b0 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL reset_drops_req: ReadValid=%b ReqReady=%b ReadData=%h required 0 0 00000000",
                     ReadValid, ReqReady, ReadData);
        end
        Reset = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        checks++;
        if (ReqReady !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear_ready: ReqReady=%b required 0", ReqReady);
        end
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        model_clear();
        n = 0;
        while (n < 1500) begin
            @(posedge clk); #1; n++;
            if (ReqReady === 1'b1) break;
        end
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL restart_clear_length: ReqReady rose after %0d cycles required 1024", n);
        end
        drive(1, 64'h10, 0, 1, 4'h0, 32'h0, e_rv, e_mis, e_rd);
        checks++;
        if (ReadValid !== 1'b1 || ReadData !== 32'h0) begin
            failures++;
            $display("FAIL cleared_after_restart: ReadValid=%b ReadData=%h required 1 00000000", ReadValid, ReadData);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_byte_enable();
        test_misalign();
        test_read_write_same_cycle();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
